// File: rtl/fact_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fact_pkg
//  Description : Shared types and constants for the factorial sequencer:
//                state encoding, parameter defaults and bus widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package fact_pkg;

    // Controller state encoding (3-bit)
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_MUL_REQ  = 3'd2,
        ST_MUL_WAIT = 3'd3,
        ST_MUL_CLR  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    // 20! is the largest factorial representable in signed 64 bits
    localparam int MAX_N_DEFAULT   = 20;
    // Cycles budgeted for the multiplier before declaring a timeout
    localparam int TIMEOUT_DEFAULT = 16;

    // Operand widths of the shared Booth multiplier
    localparam int DATA_W = 64;
    localparam int ARG_W  = 6;

    localparam logic [DATA_W-1:0] ONE = 64'd1;

endpackage
`default_nettype wire

// File: rtl/factorial_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : factorial_ctrl_if
//  Description : Bundles the user-side controls and the multiplier handshake
//                of the factorial sequencer. The slave modport is the
//                sequencer; the master modport is its environment (user logic
//                plus the multiplier instance).
//  Revision    : 1.0 - initial release
// ============================================================================
interface factorial_ctrl_if;
    import fact_pkg::*;

    // User side
    logic              op_start;
    logic              op_clear;
    logic [ARG_W-1:0]  n;
    logic [DATA_W-1:0] result;
    logic              op_done;
    logic              error;
    logic              busy;

    // Multiplier side
    logic              mul_start;
    logic              mul_clear;
    logic [DATA_W-1:0] mul_mtplicand;
    logic [ARG_W-1:0]  mul_mtplier;
    logic              mul_done;
    logic [DATA_W-1:0] mul_result;

    modport slave (
        input  op_start, op_clear, n, mul_done, mul_result,
        output result, op_done, error, busy,
               mul_start, mul_clear, mul_mtplicand, mul_mtplier
    );

    modport master (
        output op_start, op_clear, n, mul_done, mul_result,
        input  result, op_done, error, busy,
               mul_start, mul_clear, mul_mtplicand, mul_mtplier
    );

endinterface
`default_nettype wire

// File: rtl/factorial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : factorial_ctrl
//  Description : Computes N! by repeatedly driving an external radix-4 Booth
//                multiplier: acc <- acc * k, k <- k - 1 until k <= 1.
//                Reports the result with done/error status and guards each
//                multiply with a timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module factorial_ctrl
    import fact_pkg::*;
#(
    parameter int MAX_N   = MAX_N_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    factorial_ctrl_if.slave  bus
);

    localparam int                    c_TIMER_W    = $clog2(TIMEOUT + 1);
    localparam logic [ARG_W-1:0]      c_MAX_K      = ARG_W'(MAX_N);
    // Timer value on the last MUL_WAIT cycle: the increment would reach TIMEOUT-1
    localparam logic [c_TIMER_W-1:0]  c_TIMER_LAST = c_TIMER_W'(TIMEOUT - 2);

    state_t              r_state;
    logic [DATA_W-1:0]   r_acc;
    logic [ARG_W-1:0]    r_k;
    logic [c_TIMER_W-1:0] r_timer;
    logic [DATA_W-1:0]   r_result;
    logic                r_op_done;
    logic                r_error;
    logic                r_busy;
    logic                r_mul_start;
    logic                r_mul_clear;
    logic [DATA_W-1:0]   r_mul_mtplicand;

    state_t              w_state_nxt;
    logic [DATA_W-1:0]   w_acc_nxt;
    logic [ARG_W-1:0]    w_k_nxt;
    logic [c_TIMER_W-1:0] w_timer_nxt;
    logic [DATA_W-1:0]   w_result_nxt;
    logic                w_error_nxt;
    logic                w_op_done_nxt;
    logic                w_busy_nxt;
    logic                w_mul_start_nxt;
    logic                w_mul_clear_nxt;

    // Next-state, datapath and output decode; outputs follow the next state so
    // that their registered copies line up with the state they belong to
    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_k_nxt      = r_k;
        w_timer_nxt  = r_timer;
        w_result_nxt = r_result;
        w_error_nxt  = r_error;

        case (r_state)
            ST_IDLE: begin
                if (bus.op_start) begin
                    w_k_nxt     = bus.n;
                    w_acc_nxt   = ONE;
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (r_k > c_MAX_K) begin
                    w_result_nxt = '0;
                    w_error_nxt  = 1'b1;
                    w_state_nxt  = ST_DONE;
                end else if (r_k <= 6'd1) begin
                    w_result_nxt = r_acc;
                    w_state_nxt  = ST_DONE;
                end else begin
                    w_state_nxt  = ST_MUL_REQ;
                end
            end
            ST_MUL_REQ: begin
                w_timer_nxt = '0;
                w_state_nxt = ST_MUL_WAIT;
            end
            ST_MUL_WAIT: begin
                if (bus.mul_done) begin
                    w_acc_nxt   = bus.mul_result;
                    w_k_nxt     = r_k - 6'd1;
                    w_state_nxt = ST_MUL_CLR;
                end else if (r_timer == c_TIMER_LAST) begin
                    w_error_nxt  = 1'b1;
                    w_result_nxt = '0;
                    w_state_nxt  = ST_DONE;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_MUL_CLR: begin
                w_state_nxt = ST_CHECK;
            end
            ST_DONE: begin
                // Clear has priority; a concurrent start is picked up in IDLE
                if (bus.op_clear) begin
                    w_result_nxt = '0;
                    w_error_nxt  = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_op_done_nxt   = (w_state_nxt == ST_DONE);
        w_busy_nxt      = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
        w_mul_start_nxt = (w_state_nxt == ST_MUL_REQ);
        w_mul_clear_nxt = (w_state_nxt == ST_MUL_CLR);
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_acc           <= ONE;
            r_k             <= '0;
            r_timer         <= '0;
            r_result        <= '0;
            r_op_done       <= 1'b0;
            r_error         <= 1'b0;
            r_busy          <= 1'b0;
            r_mul_start     <= 1'b0;
            r_mul_clear     <= 1'b0;
            r_mul_mtplicand <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_acc           <= w_acc_nxt;
            r_k             <= w_k_nxt;
            r_timer         <= w_timer_nxt;
            r_result        <= w_result_nxt;
            r_op_done       <= w_op_done_nxt;
            r_error         <= w_error_nxt;
            r_busy          <= w_busy_nxt;
            r_mul_start     <= w_mul_start_nxt;
            r_mul_clear     <= w_mul_clear_nxt;
            // Mirrors acc so the operand output reads 0 out of reset;
            // acc only moves in IDLE and on mul_done, keeping it stable
            // from MUL_REQ until the product is captured
            r_mul_mtplicand <= w_acc_nxt;
        end
    end

    assign bus.result        = r_result;
    assign bus.op_done       = r_op_done;
    assign bus.error         = r_error;
    assign bus.busy          = r_busy;
    assign bus.mul_start     = r_mul_start;
    assign bus.mul_clear     = r_mul_clear;
    assign bus.mul_mtplicand = r_mul_mtplicand;
    assign bus.mul_mtplier   = r_k;

endmodule
`default_nettype wire
